// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-addressed load/store initiator driving a word-addressed synchronous memory
module mem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WRITE, RESP} state_t;
   state_t state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic        bad_f3, misalign, out_range, req_err;
   logic [7:0]  rd_b;
   logic [15:0] rd_h;
   logic [31:0] ld_val, st_val;
   // request checks on the live inputs, and load extraction / store merge on the captured word
   always_comb begin
      bad_f3    = req_we ? (req_funct3 > 3'b010) : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      out_range = {2'b00, req_addr[31:2]} >= DEPTH_WORDS;
      req_err   = bad_f3 || misalign || out_range;
      rd_b      = mem_read_data[{lane_q, 3'b000} +: 8];
      rd_h      = mem_read_data[{lane_q[1], 4'b0000} +: 16];
      ld_val    = f3_q[1:0] == 2'b00 ? {{24{rd_b[7] & ~f3_q[2]}}, rd_b} :
                  f3_q[1:0] == 2'b01 ? {{16{rd_h[15] & ~f3_q[2]}}, rd_h} : mem_read_data;
      st_val    = mem_read_data;
      if (f3_q[1:0] == 2'b00)
         st_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         st_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end
   // control FSM with all outputs registered; write strobe only ever asserted in WRITE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         we_q           <= 1'b0;
         f3_q           <= '0;
         lane_q         <= '0;
         wdata_q        <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               we_q      <= req_we;
               f3_q      <= req_funct3;
               lane_q    <= req_addr[1:0];
               wdata_q   <= req_wdata[15:0];
               if (req_err) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  mem_addr       <= {2'b00, req_addr[31:2]};
                  mem_write_data <= req_wdata;
                  if (req_we && req_funct3 == 3'b010) begin
                     state        <= WRITE;
                     mem_write_en <= 1'b1;
                  end else
                     state <= RD_ISSUE;
               end
            end
            RD_ISSUE: state <= RD_CAPTURE;
            RD_CAPTURE: if (we_q) begin
               mem_write_data <= st_val;
               mem_write_en   <= 1'b1;
               state          <= WRITE;
            end else begin
               rsp_rdata <= ld_val;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            WRITE: begin
               mem_write_en <= 1'b0;
               rsp_rdata    <= '0;
               rsp_err      <= 1'b0;
               rsp_valid    <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a one-cycle synchronous memory model
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data = '0;

   logic [31:0] mem [0:4095];
   int          wr_cnt = 0;
   logic [31:0] last_wa = '0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_fail = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;
   exp_t q[$];

   mem_ctrl #(.DEPTH_WORDS(4096)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr[11:0]] <= mem_write_data;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= mem_addr;
      end
      mem_read_data <= mem[mem_addr[11:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata %08h err %0d expected no response", rsp_rdata, rsp_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("rsp_cycle", cyc, e.due);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL idle_timeout: got req_ready 0 expected 1");
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      req_valid = 1'b1;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat);
      wait_idle();
      drive(we, f3, a, wd);
      q.push_back('{er, ee, cyc + lat});
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL rsp_timeout: got no response expected rdata %08h", er);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
      chk({tag, "_mem_write_en"}, {31'b0, mem_write_en}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_write_data"}, mem_write_data, 32'd0);
   endtask

   initial begin
      int w0;
      mem[0]    = 32'h8899AABB;
      mem[4]    = 32'h0;
      mem[4095] = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      do_req(0, 3'b010, 32'h0, 0, 32'h8899AABB, 0, 3);
      do_req(0, 3'b000, 32'h1, 0, 32'hFFFFFFAA, 0, 3);
      do_req(0, 3'b100, 32'h1, 0, 32'h000000AA, 0, 3);
      do_req(0, 3'b001, 32'h2, 0, 32'hFFFF8899, 0, 3);
      do_req(0, 3'b101, 32'h2, 0, 32'h00008899, 0, 3);
      do_req(0, 3'b000, 32'h0, 0, 32'hFFFFFFBB, 0, 3);
      do_req(0, 3'b101, 32'h0, 0, 32'h0000AABB, 0, 3);
      do_req(0, 3'b010, 32'h3FFC, 0, 32'hCAFEF00D, 0, 3);

      w0 = wr_cnt;
      do_req(1, 3'b010, 32'h10, 32'h11223344, 0, 0, 2);
      chk("sw_writes", wr_cnt - w0, 1);
      chk("sw_waddr", last_wa, 32'd4);
      chk("sw_word", mem[4], 32'h11223344);
      w0 = wr_cnt;
      do_req(1, 3'b000, 32'h12, 32'hABCD12EE, 0, 0, 4);
      chk("sb_writes", wr_cnt - w0, 1);
      chk("sb_word", mem[4], 32'h11EE3344);
      w0 = wr_cnt;
      do_req(1, 3'b001, 32'h10, 32'h5555BEEF, 0, 0, 4);
      chk("sh_writes", wr_cnt - w0, 1);
      chk("sh_word", mem[4], 32'h11EEBEEF);
      do_req(1, 3'b000, 32'h13, 32'h0000007F, 0, 0, 4);
      chk("sb_lane3_word", mem[4], 32'h7FEEBEEF);
      do_req(0, 3'b001, 32'h10, 0, 32'hFFFFBEEF, 0, 3);
      do_req(0, 3'b000, 32'h13, 0, 32'h0000007F, 0, 3);

      w0 = wr_cnt;
      do_req(0, 3'b010, 32'h6, 0, 0, 1, 1);
      do_req(1, 3'b001, 32'h3, 32'hFFFF, 0, 1, 1);
      do_req(0, 3'b011, 32'h0, 0, 0, 1, 1);
      do_req(0, 3'b110, 32'h0, 0, 0, 1, 1);
      do_req(1, 3'b100, 32'h0, 32'h1, 0, 1, 1);
      do_req(0, 3'b010, 32'h4000, 0, 0, 1, 1);
      do_req(1, 3'b010, 32'h4000, 32'h1, 0, 1, 1);
      chk("err_writes", wr_cnt - w0, 0);
      chk("err_mem0", mem[0], 32'h8899AABB);

      wait_idle();
      drive(0, 3'b100, 32'h1, 0);
      q.push_back('{32'h000000AA, 1'b0, cyc + 3});
      begin
         bit seen = 0;
         for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
            if (rsp_valid) seen = 1;
            req_addr = 32'h3 + 32'(i);
            req_funct3 = 3'b010;
         end
         req_valid = 1'b0;
         if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL hs_timeout: got no response expected one");
            q.delete();
         end
      end
      @(negedge clk);
      chk("hs_ready_back", {31'b0, req_ready}, 32'd1);

      w0 = wr_cnt;
      drive(1, 3'b000, 32'h0, 32'h55);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("midop_ready_after", {31'b0, req_ready}, 32'd1);
      chk("midop_writes", wr_cnt - w0, 0);
      chk("midop_mem0", mem[0], 32'h8899AABB);
      do_req(0, 3'b010, 32'h0, 0, 32'h8899AABB, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog");
   end
endmodule
